// File: rtl/algo_ctr_pkg.sv
// Shared types for the counter read-modify-write pipeline.
// Op codes travel down the pipe; state_e drives the init sweep.
package algo_ctr_pkg;

  typedef enum logic [1:0] {
    NOP,
    RD,
    WR,
    CNT
  } op_e;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/algo_ctr_fwd_hist.sv
// Short history of recent port-A writes for read-during-write bypass.
// Entry 0 is the newest write; lookup returns the newest address match.
module algo_ctr_fwd_hist #(
  parameter int WIDTH   = 64,
  parameter int BITADDR = 11,
  parameter int DEPTH   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  logic [BITADDR-1:0] waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [BITADDR-1:0] raddr_i,
  output logic               hit_o,
  output logic [WIDTH-1:0]   hdata_o
);

  logic [DEPTH-1:0]   vld_q;
  logic [BITADDR-1:0] adr_q [DEPTH];
  logic [WIDTH-1:0]   dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= wr_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    adr_q[0] <= waddr_i;
    dat_q[0] <= wdata_i;
    for (int i = 1; i < DEPTH; i++) begin
      adr_q[i] <= adr_q[i-1];
      dat_q[i] <= dat_q[i-1];
    end
  end

  // Scan oldest to newest so the newest match wins.
  always_comb begin
    hit_o   = 1'b0;
    hdata_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && adr_q[i] == raddr_i) begin
        hit_o   = 1'b1;
        hdata_o = dat_q[i];
      end
    end
  end

endmodule

// File: rtl/algo_ctr_rmw_pipe.sv
// Counter RMW pipeline over a single-read/single-write SRAM.
// Zero-fills the SRAM after reset, then takes one op per cycle.
module algo_ctr_rmw_pipe
  import algo_ctr_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int NUMADDR    = 2048,
  parameter int BITADDR    = 11,
  parameter int SRAM_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               cnt,
  input  logic [BITADDR-1:0] ct_adr,
  input  logic [WIDTH-1:0]   ct_imm,
  input  logic               ac_read,
  input  logic               ac_write,
  input  logic [BITADDR-1:0] ac_addr,
  input  logic [WIDTH-1:0]   ac_din,
  output logic               ac_vld,
  output logic [WIDTH-1:0]   ac_dout,
  output logic               t1_readB,
  output logic [BITADDR-1:0] t1_addrB,
  input  logic [WIDTH-1:0]   t1_doutB,
  output logic               t1_writeA,
  output logic [BITADDR-1:0] t1_addrA,
  output logic [WIDTH-1:0]   t1_dinA
);

  localparam logic [BITADDR-1:0] LAST = BITADDR'(NUMADDR - 1);

  state_e             state_q;
  logic [BITADDR-1:0] ptr_q;
  logic               run_q;

  op_e                op_q  [SRAM_DELAY];
  logic [BITADDR-1:0] adr_q [SRAM_DELAY];
  logic [WIDTH-1:0]   dat_q [SRAM_DELAY];

  op_e                op_d;
  logic [BITADDR-1:0] adr_d;
  logic [WIDTH-1:0]   dat_d;

  op_e                op_t;
  logic [BITADDR-1:0] adr_t;
  logic [WIDTH-1:0]   dat_t;
  logic               hit;
  logic [WIDTH-1:0]   hdata;
  logic [WIDTH-1:0]   old;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (ptr_q == LAST) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= INIT;
      endcase
    end
  end

  assign ready = run_q & ~rst;

  // Fixed priority: write, then counter add, then read.
  always_comb begin
    op_d     = NOP;
    adr_d    = '0;
    dat_d    = '0;
    t1_readB = 1'b0;
    t1_addrB = '0;
    if (ready) begin
      if (ac_write) begin
        op_d  = WR;
        adr_d = ac_addr;
        dat_d = ac_din;
      end else if (cnt) begin
        op_d     = CNT;
        adr_d    = ct_adr;
        dat_d    = ct_imm;
        t1_readB = 1'b1;
        t1_addrB = ct_adr;
      end else if (ac_read) begin
        op_d     = RD;
        adr_d    = ac_addr;
        t1_readB = 1'b1;
        t1_addrB = ac_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SRAM_DELAY; i++) begin
        op_q[i] <= NOP;
      end
    end else begin
      op_q[0] <= op_d;
      for (int i = 1; i < SRAM_DELAY; i++) begin
        op_q[i] <= op_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    adr_q[0] <= adr_d;
    dat_q[0] <= dat_d;
    for (int i = 1; i < SRAM_DELAY; i++) begin
      adr_q[i] <= adr_q[i-1];
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign op_t  = op_q[SRAM_DELAY-1];
  assign adr_t = adr_q[SRAM_DELAY-1];
  assign dat_t = dat_q[SRAM_DELAY-1];

  algo_ctr_fwd_hist #(
    .WIDTH  (WIDTH),
    .BITADDR(BITADDR),
    .DEPTH  (SRAM_DELAY)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .wr_i   (t1_writeA),
    .waddr_i(t1_addrA),
    .wdata_i(t1_dinA),
    .raddr_i(adr_t),
    .hit_o  (hit),
    .hdata_o(hdata)
  );

  // SRAM data misses writes issued since the read; bypass them.
  assign old = hit ? hdata : t1_doutB;

  always_comb begin
    t1_writeA = 1'b0;
    t1_addrA  = '0;
    t1_dinA   = '0;
    ac_vld    = 1'b0;
    ac_dout   = '0;
    if (!rst) begin
      if (state_q == INIT) begin
        t1_writeA = 1'b1;
        t1_addrA  = ptr_q;
      end else begin
        case (op_t)
          WR: begin
            t1_writeA = 1'b1;
            t1_addrA  = adr_t;
            t1_dinA   = dat_t;
          end
          CNT: begin
            t1_writeA = 1'b1;
            t1_addrA  = adr_t;
            t1_dinA   = old + dat_t;
          end
          RD: begin
            ac_vld  = 1'b1;
            ac_dout = old;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_algo_ctr_rmw_pipe.sv
// Bench for algo_ctr_rmw_pipe at SRAM_DELAY 1 and 3 side by side.
// Each copy has an SRAM model and a sequential reference scoreboard.
module tb_algo_ctr_rmw_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt;
  logic [10:0] ct_adr;
  logic [63:0] ct_imm;
  logic        ac_read;
  logic        ac_write;
  logic [10:0] ac_addr;
  logic [63:0] ac_din;

  logic [1:0]        rdy_w;
  logic [1:0]        vld_w;
  logic [1:0][63:0]  dout_w;
  logic [1:0]        rB_w;
  logic [1:0][10:0]  aB_w;
  logic [1:0][63:0]  qB_w;
  logic [1:0]        wA_w;
  logic [1:0][10:0]  aA_w;
  logic [1:0][63:0]  dA_w;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    int          due;
    logic        rd;
    logic [10:0] a;
    logic [63:0] d;
  } ev_t;

  always #5 clk = ~clk;

  task automatic chk(input int d, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40)
        $display("FAIL [D=%0d] %s: got %0h expected %0h", d, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int D = (g == 0) ? 1 : 3;

    algo_ctr_rmw_pipe #(.SRAM_DELAY(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .ready    (rdy_w[g]),
      .cnt      (cnt),
      .ct_adr   (ct_adr),
      .ct_imm   (ct_imm),
      .ac_read  (ac_read),
      .ac_write (ac_write),
      .ac_addr  (ac_addr),
      .ac_din   (ac_din),
      .ac_vld   (vld_w[g]),
      .ac_dout  (dout_w[g]),
      .t1_readB (rB_w[g]),
      .t1_addrB (aB_w[g]),
      .t1_doutB (qB_w[g]),
      .t1_writeA(wA_w[g]),
      .t1_addrA (aA_w[g]),
      .t1_dinA  (dA_w[g])
    );

    logic [63:0] sram [2048];
    logic [63:0] rp [D];

    always @(posedge clk) begin
      if (wA_w[g]) sram[aA_w[g]] <= dA_w[g];
      if (rB_w[g]) rp[0] <= sram[aB_w[g]];
      for (int i = 1; i < D; i++) rp[i] <= rp[i-1];
    end

    assign qB_w[g] = rp[D-1];

    logic [63:0] mdl [2048];
    ev_t         q [$];
    int          init_left = 0;
    int          cyc = 0;

    always @(negedge clk) begin : model
      logic        erdy, ew, erb, ev;
      logic [10:0] eaa, eab;
      logic [63:0] eda, edo;
      ev_t         e;
      cyc++;
      erdy = 0; ew = 0; erb = 0; ev = 0;
      eaa = 0; eab = 0; eda = 0; edo = 0;
      if (rst) begin
        q.delete();
        init_left = 2048;
        foreach (mdl[i]) mdl[i] = '0;
      end else if (init_left > 0) begin
        ew = 1;
        eaa = 11'(2048 - init_left);
        init_left--;
      end else begin
        erdy = 1;
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          if (e.rd) begin
            ev = 1; edo = e.d;
          end else begin
            ew = 1; eaa = e.a; eda = e.d;
          end
        end
        e.due = cyc + D;
        if (ac_write) begin
          mdl[ac_addr] = ac_din;
          e.rd = 0; e.a = ac_addr; e.d = ac_din;
          q.push_back(e);
        end else if (cnt) begin
          mdl[ct_adr] = mdl[ct_adr] + ct_imm;
          erb = 1; eab = ct_adr;
          e.rd = 0; e.a = ct_adr; e.d = mdl[ct_adr];
          q.push_back(e);
        end else if (ac_read) begin
          erb = 1; eab = ac_addr;
          e.rd = 1; e.a = ac_addr; e.d = mdl[ac_addr];
          q.push_back(e);
        end
      end
      chk(D, "ready", rdy_w[g], erdy);
      chk(D, "t1_readB", rB_w[g], erb);
      chk(D, "t1_writeA", wA_w[g], ew);
      chk(D, "ac_vld", vld_w[g], ev);
      if (erb || rst) chk(D, "t1_addrB", aB_w[g], eab);
      if (ew || rst) begin
        chk(D, "t1_addrA", aA_w[g], eaa);
        chk(D, "t1_dinA", dA_w[g], eda);
      end
      if (ev || rst) chk(D, "ac_dout", dout_w[g], edo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cnt = 0;
    ac_read = 0;
    ac_write = 0;
  endtask

  task automatic op(input bit w, input bit c, input bit r,
                    input logic [10:0] a, input logic [63:0] v);
    ac_write = w; cnt = c; ac_read = r;
    ct_adr = a; ac_addr = a; ct_imm = v; ac_din = v;
    step();
    idle();
  endtask

  task automatic read_lit(input logic [10:0] a, input logic [63:0] exp,
                          input string nm);
    int          nv [2];
    logic [63:0] got [2];
    nv[0] = 0; nv[1] = 0; got[0] = '1; got[1] = '1;
    op(0, 0, 1, a, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (vld_w[g]) begin
          nv[g]++;
          got[g] = dout_w[g];
        end
      end
      step();
    end
    for (int g = 0; g < 2; g++) begin
      chk(g ? 3 : 1, {nm, " vld count"}, nv[g], 1);
      chk(g ? 3 : 1, {nm, " data"}, got[g], exp);
    end
  endtask

  task automatic wait_ready(input bit drive_cnt, output int n, output int nrb);
    n = 0;
    nrb = 0;
    if (drive_cnt) begin
      cnt = 1; ct_adr = 11'd1; ct_imm = 64'd3;
    end
    while (n < 3000) begin
      if (rdy_w[0] === 1'b1) break;
      n++;
      if (n == 100) idle();
      step();
      if (rB_w != 2'b00) nrb++;
    end
  endtask

  initial begin
    int n, nrb;
    rst = 1;
    idle();
    ct_adr = 0; ct_imm = 0; ac_addr = 0; ac_din = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    wait_ready(0, n, nrb);
    chk(0, "init ready-low cycles", n, 2048);
    chk(0, "ready both copies", rdy_w, 2'b11);
    read_lit(11'd5, 64'd0, "read 5 after init");

    repeat (4) op(0, 1, 0, 11'd7, 64'd1);
    read_lit(11'd7, 64'd4, "cnt x4 addr 7");

    op(1, 0, 0, 11'd3, '1);
    op(0, 1, 0, 11'd3, 64'd2);
    read_lit(11'd3, 64'd1, "wrap addr 3");

    ac_write = 1; ac_addr = 11'd9; ac_din = 64'd10;
    cnt = 1; ct_adr = 11'd9; ct_imm = 64'd5;
    step();
    idle();
    read_lit(11'd9, 64'd10, "write beats cnt");

    op(0, 1, 1, 11'd7, 64'd5);
    read_lit(11'd7, 64'd9, "cnt beats read");

    for (int i = 0; i < 60; i++) begin
      case (i % 4)
        0: op(1, 0, 0, 11'(20 + i % 3), 64'(i * 7 + 1));
        1: op(0, 1, 0, 11'(20 + i % 3), 64'(i * 7 + 1));
        2: op(0, 0, 1, 11'(20 + i % 3), 64'd0);
        default: op(0, 1, 1, 11'(20 + i % 3), 64'(i));
      endcase
    end
    repeat (5) step();

    ac_read = 1; ac_addr = 11'd7;
    step();
    step();
    idle();
    rst = 1;
    step();
    rst = 0;
    wait_ready(1, n, nrb);
    chk(0, "re-init ready-low cycles", n, 2048);
    chk(0, "t1 reads during init", nrb, 0);
    read_lit(11'd7, 64'd0, "addr 7 after re-init");
    read_lit(11'd1, 64'd0, "addr 1 cnt ignored in init");

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
